// File: rtl/door_open_if.sv
// door_open_if: signal bundle between the door-open controller and its environment.
interface door_open_if;
    logic arrive;
    logic r;
    logic close_signal;
    logic open_signal;
    logic c_100;
    logic door_open;
    modport master (output arrive, r, close_signal, input open_signal, c_100, door_open);
    modport slave (input arrive, r, close_signal, output open_signal, c_100, door_open);
endinterface

// File: rtl/door_open.sv
// door_open: elevator car door-open controller (open drive, dwell, close permit, close watch).
// Define DOOR_REOPEN_EN to let an open-button press during closing reopen the door.
module door_open #(
    parameter int OPEN_TIME = 4,
    parameter int HOLD_TIME = 20,
    parameter int C_WIDTH   = 2
) (
    input logic         clk,
    input logic         rst,
    door_open_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, OPENING, HOLD, PROMPT, WAIT_CLOSE} state_t;
    localparam logic [7:0] OPEN_LAST = 8'(OPEN_TIME - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TIME - 1);
    localparam logic [7:0] C_LAST    = 8'(C_WIDTH - 1);
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       seen, seen_n;
    logic       open_q, open_n;
    logic       c_q, c_n;
    logic       door_q, door_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            seen   <= 1'b0;
            open_q <= 1'b0;
            c_q    <= 1'b0;
            door_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            seen   <= seen_n;
            open_q <= open_n;
            c_q    <= c_n;
            door_q <= door_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        seen_n  = seen;
        open_n  = open_q;
        c_n     = c_q;
        door_n  = door_q;
        case (state)
            IDLE: begin
                if (bus.arrive || bus.r) begin
                    state_n = OPENING;
                    cnt_n   = '0;
                    open_n  = 1'b1;
                end
            end
            OPENING: begin
                if (cnt == OPEN_LAST) begin
                    state_n = HOLD;
                    open_n  = 1'b0;
                    door_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HOLD: begin
                // a press restarts the dwell rather than pausing it
                if (bus.r) begin
                    cnt_n = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_n = PROMPT;
                    c_n     = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PROMPT: begin
                if (bus.r) begin
                    state_n = HOLD;
                    c_n     = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == C_LAST) begin
                    state_n = WAIT_CLOSE;
                    c_n     = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WAIT_CLOSE: begin
`ifdef DOOR_REOPEN_EN
                if (bus.r && bus.close_signal) begin
                    state_n = OPENING;
                    open_n  = 1'b1;
                    cnt_n   = '0;
                    seen_n  = 1'b0;
                end else
`endif
                if (bus.close_signal) begin
                    seen_n = 1'b1;
                end else if (seen) begin
                    state_n = IDLE;
                    door_n  = 1'b0;
                    seen_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.open_signal = open_q;
    assign bus.c_100       = c_q;
    assign bus.door_open   = door_q;
endmodule
